// File: rtl/rc6_pkg.sv
// RC6-32/20 shared constants, types and helpers.
// Used by the key-expansion engine and its mix step.
package rc6_pkg;

    localparam logic [31:0] P32         = 32'hB7E15163;
    localparam logic [31:0] Q32         = 32'h9E3779B9;
    localparam int          ROUNDS      = 20;
    localparam int          T           = 2 * ROUNDS + 4;
    localparam int          KEY_ENTRIES = T / 2;

    typedef logic [31:0] word_t;

    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        INIT  = 5'b00010,
        MIX   = 5'b00100,
        WRITE = 5'b01000,
        DONE  = 5'b10000
    } state_t;

    function automatic word_t rotl(word_t x, logic [4:0] n);
        logic [63:0] t;
        t = {x, x} << n;
        return t[63:32];
    endfunction

endpackage

// File: rtl/rc6_key_sched_mix.sv
// One RC6 key-mixing iteration, purely combinational.
// Produces the new A (next S[i]) and new B (next L[j]).
module rc6_mix_step
    import rc6_pkg::*;
(
    input  word_t s_i,
    input  word_t l_j,
    input  word_t a,
    input  word_t b,
    output word_t a_n,
    output word_t b_n
);

    word_t ab;

    // A' = rotl(S+A+B,3); B' = rotl(L+A'+B, A'+B)
    always_comb begin
        a_n = rotl(s_i + a + b, 5'd3);
        ab  = a_n + b;
        b_n = rotl(l_j + a_n + b, ab[4:0]);
    end

endmodule

// File: rtl/rc6_key_sched.sv
// RC6 key-expansion engine: INIT, MIX, then 22 store writes.
// Writes {S[2k],S[2k+1]} at address k into the round-key RAM.
module rc6_key_sched #(
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [32*KEY_WORDS-1:0] key_in,
    output logic                    busy,
    output logic                    done,
    output logic                    key_we,
    output logic [4:0]              key_addr,
    output logic [63:0]             key_wdata
);
    import rc6_pkg::*;

    localparam int TT   = 2 * ROUNDS + 4;
    localparam int MIXN = 3 * ((KEY_WORDS > TT) ? KEY_WORDS : TT);
    localparam int JW   = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;

    state_t        state;
    state_t        state_d;
    word_t         s [TT];
    word_t         l [KEY_WORDS];
    word_t         acc;
    word_t         a;
    word_t         b;
    word_t         a_n;
    word_t         b_n;
    logic [5:0]    i;
    logic [JW-1:0] j;
    logic [7:0]    mcnt;
    logic [4:0]    k;
    logic          i_last;
    logic          j_last;
    logic          m_last;
    logic          w_last;

    assign i_last = (i == 6'(TT - 1));
    assign j_last = (j == JW'(KEY_WORDS - 1));
    assign m_last = (mcnt == 8'(MIXN - 1));
    assign w_last = (k == 5'(KEY_ENTRIES));

    rc6_mix_step u_mix (
        .s_i (s[i]),
        .l_j (l[j]),
        .a   (a),
        .b   (b),
        .a_n (a_n),
        .b_n (b_n)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state decode
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE:    if (start)  state_d = INIT;
            INIT:    if (i_last) state_d = MIX;
            MIX:     if (m_last) state_d = WRITE;
            WRITE:   if (w_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters, mix registers and registered store-write outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            key_we    <= 1'b0;
            key_addr  <= '0;
            key_wdata <= '0;
            acc       <= '0;
            a         <= '0;
            b         <= '0;
            i         <= '0;
            j         <= '0;
            mcnt      <= '0;
            k         <= '0;
        end else begin
            done   <= 1'b0;
            key_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        acc  <= P32;
                        i    <= '0;
                    end
                end
                INIT: begin
                    acc <= acc + Q32;
                    i   <= i_last ? '0 : i + 6'd1;
                    if (i_last) begin
                        a    <= '0;
                        b    <= '0;
                        j    <= '0;
                        mcnt <= '0;
                    end
                end
                MIX: begin
                    a    <= a_n;
                    b    <= b_n;
                    i    <= i_last ? '0 : i + 6'd1;
                    j    <= j_last ? '0 : j + JW'(1);
                    mcnt <= mcnt + 8'd1;
                    // S[0],S[1] are final long before the last
                    // iteration, so entry 0 goes out on WRITE entry.
                    if (m_last) begin
                        key_we    <= 1'b1;
                        key_addr  <= 5'd0;
                        key_wdata <= {s[0], s[1]};
                        k         <= 5'd1;
                    end
                end
                WRITE: begin
                    if (w_last) begin
                        done <= 1'b1;
                    end else begin
                        key_we    <= 1'b1;
                        key_addr  <= k;
                        key_wdata <= {s[{k, 1'b0}], s[{k, 1'b1}]};
                        k         <= k + 5'd1;
                    end
                end
                DONE:    busy <= 1'b0;
                default: ;
            endcase
        end
    end

    // S and L arrays; contents are don't-care until a run fills them
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            for (int n = 0; n < KEY_WORDS; n++) begin
                l[n] <= key_in[32*n +: 32];
            end
        end
        if (state == INIT) begin
            s[i] <= acc;
        end
        if (state == MIX) begin
            s[i] <= a_n;
            l[j] <= b_n;
        end
    end

endmodule
